// File: rtl/l2_lrsc_requester.sv
// Per-port LR/SC/AMO/load/store initiator into the L2 arbiter.
// Holds a shadow reservation so a doomed SC fails locally without an L2 request.
module l2_lrsc_requester #(
    parameter int unsigned     ID_W       = 1,
    parameter logic [ID_W-1:0] PORT_ID    = '0,
    parameter int unsigned     LR_TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            core_req_i,
    output logic            core_ready_o,
    input  logic [2:0]      core_op_i,
    input  logic [29:0]     core_addr_i,
    input  logic [31:0]     core_wdata_i,
    output logic            core_done_o,
    output logic [31:0]     core_rdata_o,
    output logic            core_sc_result_o,

    output logic            l2_request_o,
    input  logic            l2_ack_i,
    output logic [29:0]     l2_addr_o,
    output logic [ID_W-1:0] l2_id_o,
    output logic            l2_lr_o,
    output logic            l2_sc_o,
    output logic            l2_store_o,
    output logic [31:0]     l2_wdata_o,
    input  logic            l2_abort_i,
    input  logic            l2_rd_valid_i,
    input  logic [31:0]     l2_rd_data_i,

    input  logic            inv_valid_i,
    input  logic [29:0]     inv_addr_i
);

    localparam int unsigned CntW = (LR_TIMEOUT > 0) ? $clog2(LR_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LR_TIMEOUT);

    localparam logic [2:0] OpLoad  = 3'd0;
    localparam logic [2:0] OpStore = 3'd1;
    localparam logic [2:0] OpLr    = 3'd2;
    localparam logic [2:0] OpSc    = 3'd3;
    localparam logic [2:0] OpAmo   = 3'd4;

    typedef enum logic [2:0] {StIdle, StReq, StWaitRd, StLfail, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [29:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            sc_res_q, sc_res_d;
    logic            res_valid_q, res_valid_d;
    logic [29:0]     res_addr_q, res_addr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            sc_clear, lr_set, wr_clear, inv_hit, res_hit;
    logic [CntW-1:0] cnt_nxt;

    assign res_hit = res_valid_q && (res_addr_q == core_addr_i);
    assign inv_hit = inv_valid_i && (inv_addr_i == res_addr_q);
    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        sc_res_d = sc_res_q;
        sc_clear = 1'b0;
        lr_set   = 1'b0;
        wr_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (core_req_i) begin
                    op_d     = (core_op_i > OpAmo) ? OpLoad : core_op_i;
                    addr_d   = core_addr_i;
                    wdata_d  = core_wdata_i;
                    sc_res_d = 1'b0;
                    if (core_op_i == OpSc) begin
                        sc_clear = 1'b1;
                        state_d  = res_hit ? StReq : StLfail;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (l2_ack_i) begin
                    case (op_q)
                        OpStore: state_d = StDone;
                        OpSc: begin
                            sc_res_d = l2_abort_i;
                            state_d  = StDone;
                        end
                        default: state_d = StWaitRd;
                    endcase
                    lr_set   = (op_q == OpLr);
                    wr_clear = ((op_q == OpStore) || (op_q == OpAmo)) && (addr_q == res_addr_q);
                end
            end
            StWaitRd: begin
                if (l2_rd_valid_i) begin
                    rdata_d = l2_rd_data_i;
                    state_d = StDone;
                end
            end
            StLfail: begin
                sc_res_d = 1'b1;
                state_d  = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reservation: an LR ack overrides older state, but a same-cycle invalidate of it still wins.
    always_comb begin
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        cnt_d       = cnt_q;
        if (res_valid_q && (LR_TIMEOUT != 0)) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_nxt;
            end
            if (cnt_nxt == CntMax) begin
                res_valid_d = 1'b0;
            end
        end
        if (inv_hit || wr_clear || sc_clear) begin
            res_valid_d = 1'b0;
        end
        if (lr_set) begin
            res_addr_d  = addr_q;
            cnt_d       = '0;
            res_valid_d = !(inv_valid_i && (inv_addr_i == addr_q));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            op_q        <= OpLoad;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sc_res_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sc_res_q    <= sc_res_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign core_ready_o     = (state_q == StIdle);
    assign core_done_o      = (state_q == StDone);
    assign core_rdata_o     = rdata_q;
    assign core_sc_result_o = sc_res_q;

    assign l2_request_o = (state_q == StReq);
    assign l2_addr_o    = addr_q;
    assign l2_wdata_o   = wdata_q;
    assign l2_id_o      = PORT_ID;
    assign l2_lr_o      = l2_request_o && (op_q == OpLr);
    assign l2_sc_o      = l2_request_o && (op_q == OpSc);
    assign l2_store_o   = l2_request_o && ((op_q == OpStore) || (op_q == OpSc) || (op_q == OpAmo));

endmodule

// File: tb/tb_l2_lrsc_requester.sv
// Randomised bench for l2_lrsc_requester; acts as core and as L2 arbiter, with a
// transaction-level reservation model (valid, address, ack cycle).
module tb_l2_lrsc_requester;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_ready, core_done, core_sc_result;
    logic [2:0]  core_op;
    logic [29:0] core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        l2_request, l2_ack, l2_lr, l2_sc, l2_store, l2_abort;
    logic [29:0] l2_addr;
    logic [1:0]  l2_id;
    logic [31:0] l2_wdata, l2_rd_data;
    logic        l2_rd_valid, inv_valid;
    logic [29:0] inv_addr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit          m_res_v;
    logic [29:0] m_res_a;
    int          m_res_cyc;

    l2_lrsc_requester #(.ID_W(2), .PORT_ID(2'd2), .LR_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_ready_o(core_ready), .core_op_i(core_op),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_done_o(core_done),
        .core_rdata_o(core_rdata), .core_sc_result_o(core_sc_result),
        .l2_request_o(l2_request), .l2_ack_i(l2_ack), .l2_addr_o(l2_addr), .l2_id_o(l2_id),
        .l2_lr_o(l2_lr), .l2_sc_o(l2_sc), .l2_store_o(l2_store), .l2_wdata_o(l2_wdata),
        .l2_abort_i(l2_abort), .l2_rd_valid_i(l2_rd_valid), .l2_rd_data_i(l2_rd_data),
        .inv_valid_i(inv_valid), .inv_addr_i(inv_addr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [29:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 30'h100;
            1: return 30'h104;
            2: return 30'h200;
            default: return 30'h040;
        endcase
    endfunction

    // Reservation usable at accept edge s: it lives for T cycles after its ack edge.
    function automatic bit res_live(input int s);
        return m_res_v && ((s - 1 - m_res_cyc) < int'(T));
    endfunction

    task automatic idle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            if (noisy) begin
                inv_valid   = ($urandom_range(0, 3) == 0);
                inv_addr    = pick_addr();
                l2_rd_valid = ($urandom_range(0, 3) == 0);
                l2_rd_data  = $urandom;
            end
            check_eq("idle_done", 32'(core_done), 32'd0);
            check_eq("idle_ready", 32'(core_ready), 32'd1);
            check_eq("idle_req", 32'(l2_request), 32'd0);
            tick();
            if (inv_valid && m_res_v && inv_addr == m_res_a) m_res_v = 1'b0;
        end
        inv_valid   = 1'b0;
        l2_rd_valid = 1'b0;
    endtask

    task automatic inv_pulse(input logic [29:0] a);
        inv_valid = 1'b1;
        inv_addr  = a;
        tick();
        if (m_res_v && a == m_res_a) m_res_v = 1'b0;
        inv_valid = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [29:0] addr, input logic [31:0] wd,
                         input int ack_dly, input int rd_dly, input bit abort, input bit inv_ack,
                         input logic [31:0] data);
        bit lfail, rd, st;
        int s;
        rd = !(op == 3'd1 || op == 3'd3);
        st = (op == 3'd1 || op == 3'd3 || op == 3'd4);
        check_eq("ready_before", 32'(core_ready), 32'd1);
        core_req    = 1'b1;
        core_op     = op;
        core_addr   = addr;
        core_wdata  = wd;
        inv_valid   = 1'b0;
        l2_rd_valid = 1'b0;
        tick();
        s          = cyc;
        core_req   = 1'b0;
        core_op    = 3'($urandom);
        core_addr  = 30'($urandom);
        core_wdata = $urandom;
        lfail = (op == 3'd3) && !(res_live(s) && m_res_a == addr);
        if (op == 3'd3) m_res_v = 1'b0;
        if (lfail) begin
            check_eq("lf_req0", 32'(l2_request), 32'd0);
            check_eq("lf_done0", 32'(core_done), 32'd0);
            tick();
            check_eq("lf_req1", 32'(l2_request), 32'd0);
            check_eq("lf_done", 32'(core_done), 32'd1);
            check_eq("lf_sc", 32'(core_sc_result), 32'd1);
            tick();
            check_eq("lf_done_end", 32'(core_done), 32'd0);
            return;
        end
        for (int i = 0; i <= ack_dly; i++) begin
            check_eq("req", 32'(l2_request), 32'd1);
            check_eq("req_addr", 32'(l2_addr), 32'(addr));
            check_eq("req_wdata", l2_wdata, wd);
            check_eq("req_lr", 32'(l2_lr), 32'(op == 3'd2));
            check_eq("req_sc", 32'(l2_sc), 32'(op == 3'd3));
            check_eq("req_store", 32'(l2_store), 32'(st));
            check_eq("req_id", 32'(l2_id), 32'd2);
            check_eq("req_done", 32'(core_done), 32'd0);
            if (i == ack_dly) begin
                l2_ack   = 1'b1;
                l2_abort = abort;
                if (inv_ack) begin
                    inv_valid = 1'b1;
                    inv_addr  = addr;
                end
            end else begin
                l2_abort = 1'($urandom);
            end
            tick();
        end
        l2_ack    = 1'b0;
        l2_abort  = 1'b0;
        inv_valid = 1'b0;
        if (op == 3'd2) begin
            m_res_v   = !inv_ack;
            m_res_a   = addr;
            m_res_cyc = cyc;
        end else if (m_res_v && m_res_a == addr && (inv_ack || op == 3'd1 || op == 3'd4)) begin
            m_res_v = 1'b0;
        end
        check_eq("req_drop", 32'(l2_request), 32'd0);
        if (!rd) begin
            check_eq("wr_done", 32'(core_done), 32'd1);
            check_eq("wr_sc", 32'(core_sc_result), (op == 3'd3) ? 32'(abort) : 32'd0);
        end else begin
            for (int i = 0; i < rd_dly; i++) begin
                check_eq("rd_wait_done", 32'(core_done), 32'd0);
                tick();
            end
            l2_rd_valid = 1'b1;
            l2_rd_data  = data;
            tick();
            l2_rd_valid = 1'b0;
            l2_rd_data  = $urandom;
            check_eq("rd_done", 32'(core_done), 32'd1);
            check_eq("rd_data", core_rdata, data);
            check_eq("rd_sc", 32'(core_sc_result), 32'd0);
        end
        tick();
        check_eq("done_end", 32'(core_done), 32'd0);
        check_eq("ready_after", 32'(core_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(core_ready), 32'd1);
        check_eq({tag, "_done"}, 32'(core_done), 32'd0);
        check_eq({tag, "_sc"}, 32'(core_sc_result), 32'd0);
        check_eq({tag, "_rdata"}, core_rdata, 32'd0);
        check_eq({tag, "_req"}, 32'(l2_request), 32'd0);
        check_eq({tag, "_flags"}, {29'd0, l2_lr, l2_sc, l2_store}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        core_req    = 1'b0;
        core_op     = '0;
        core_addr   = '0;
        core_wdata  = '0;
        l2_ack      = 1'b0;
        l2_abort    = 1'b0;
        l2_rd_valid = 1'b0;
        l2_rd_data  = '0;
        inv_valid   = 1'b0;
        inv_addr    = '0;
        m_res_v     = 1'b0;
        m_res_a     = '0;
        m_res_cyc   = 0;
        #1;
        check_reset_outputs("rst");
        check_eq("rst_id", 32'(l2_id), 32'd2);
        tick();
        tick();
        rst_n = 1'b1;
        idle(1, 1'b0);

        // LR then matching SC succeeds
        do_op(3'd2, 30'h100, 32'h0, 2, 1, 1'b0, 1'b0, 32'hDEADBEEF);
        check_eq("lr_rdata_hold", core_rdata, 32'hDEADBEEF);
        do_op(3'd3, 30'h100, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 32'h0);
        // SC without reservation
        do_op(3'd3, 30'h200, 32'h5, 1, 0, 1'b0, 1'b0, 32'h0);
        // invalidate same / other word
        do_op(3'd2, 30'h100, 32'h0, 0, 0, 1'b0, 1'b0, 32'h11);
        inv_pulse(30'h100);
        do_op(3'd3, 30'h100, 32'h6, 0, 0, 1'b0, 1'b0, 32'h0);
        do_op(3'd2, 30'h100, 32'h0, 0, 0, 1'b0, 1'b0, 32'h22);
        inv_pulse(30'h104);
        do_op(3'd3, 30'h100, 32'h7, 0, 0, 1'b0, 1'b0, 32'h0);
        // expiry: accept 4 cycles after ack still issues (abort), 5 fails locally
        do_op(3'd2, 30'h104, 32'h0, 0, 0, 1'b0, 1'b0, 32'h33);
        idle(1, 1'b0);
        do_op(3'd3, 30'h104, 32'h8, 0, 0, 1'b1, 1'b0, 32'h0);
        do_op(3'd2, 30'h104, 32'h0, 0, 0, 1'b0, 1'b0, 32'h44);
        idle(2, 1'b0);
        do_op(3'd3, 30'h104, 32'h9, 0, 0, 1'b0, 1'b0, 32'h0);
        // LR ack with same-cycle invalidate leaves no reservation
        do_op(3'd2, 30'h200, 32'h0, 1, 0, 1'b0, 1'b1, 32'h55);
        do_op(3'd3, 30'h200, 32'hA, 0, 0, 1'b0, 1'b0, 32'h0);
        // own store to reserved word kills it
        do_op(3'd2, 30'h040, 32'h0, 0, 0, 1'b0, 1'b0, 32'h66);
        do_op(3'd1, 30'h040, 32'hB, 0, 0, 1'b0, 1'b0, 32'h0);
        do_op(3'd3, 30'h040, 32'hC, 0, 0, 1'b0, 1'b0, 32'h0);
        // long-stalled store
        do_op(3'd1, 30'h3ABCDE, 32'hCAFEF00D, 10, 0, 1'b0, 1'b0, 32'h0);

        // reset while requesting
        core_req   = 1'b1;
        core_op    = 3'd1;
        core_addr  = 30'h200;
        core_wdata = 32'h77;
        tick();
        core_req = 1'b0;
        check_eq("mid_req_on", 32'(l2_request), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_req");
        tick();
        rst_n   = 1'b1;
        m_res_v = 1'b0;
        idle(2, 1'b0);

        // reset while waiting for read data
        do_op(3'd0, 30'h104, 32'h0, 0, 0, 1'b0, 1'b0, 32'hA5A5_0001);
        core_req  = 1'b1;
        core_op   = 3'd0;
        core_addr = 30'h100;
        tick();
        core_req = 1'b0;
        l2_ack   = 1'b1;
        tick();
        l2_ack = 1'b0;
        check_eq("mid_rd_done", 32'(core_done), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_rd");
        tick();
        rst_n       = 1'b1;
        l2_rd_valid = 1'b1;
        l2_rd_data  = 32'h1357_9BDF;
        tick();
        l2_rd_valid = 1'b0;
        check_eq("post_rst_done0", 32'(core_done), 32'd0);
        tick();
        check_eq("post_rst_done1", 32'(core_done), 32'd0);
        check_eq("post_rst_rdata", core_rdata, 32'd0);
        idle(1, 1'b0);

        // randomised traffic
        for (int n = 0; n < 250; n++) begin
            int r;
            logic [2:0] op;
            r = $urandom_range(0, 9);
            if (r < 3)      op = 3'd2;
            else if (r < 6) op = 3'd3;
            else            op = 3'($urandom_range(0, 7));
            do_op(op, pick_addr(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), ($urandom_range(0, 7) == 0), $urandom);
            idle($urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
